// File: rtl/lsu_pkg.sv
// Shared LSU definitions: datapath width, opcode encoding, FSM states and decode helpers.
package lsu_pkg;

   localparam int unsigned CPU_WIDTH     = 64;
   localparam int unsigned LSU_OPT_WIDTH = 4;

   localparam logic [LSU_OPT_WIDTH-1:0] LSU_NONE = 4'd0;
   localparam logic [LSU_OPT_WIDTH-1:0] LSU_LB   = 4'd1;
   localparam logic [LSU_OPT_WIDTH-1:0] LSU_LH   = 4'd2;
   localparam logic [LSU_OPT_WIDTH-1:0] LSU_LW   = 4'd3;
   localparam logic [LSU_OPT_WIDTH-1:0] LSU_LD   = 4'd4;
   localparam logic [LSU_OPT_WIDTH-1:0] LSU_LBU  = 4'd5;
   localparam logic [LSU_OPT_WIDTH-1:0] LSU_LHU  = 4'd6;
   localparam logic [LSU_OPT_WIDTH-1:0] LSU_LWU  = 4'd7;
   localparam logic [LSU_OPT_WIDTH-1:0] LSU_SB   = 4'd8;
   localparam logic [LSU_OPT_WIDTH-1:0] LSU_SH   = 4'd9;
   localparam logic [LSU_OPT_WIDTH-1:0] LSU_SW   = 4'd10;
   localparam logic [LSU_OPT_WIDTH-1:0] LSU_SD   = 4'd11;

   typedef enum logic [1:0] {SzB, SzH, SzW, SzD} lsu_size_e;
   typedef enum logic [1:0] {StIdle, StReq, StWaitR, StDone} lsu_state_e;

   function automatic logic opt_is_load(input logic [LSU_OPT_WIDTH-1:0] opt);
      return (opt >= LSU_LB) && (opt <= LSU_LWU);
   endfunction

   function automatic logic opt_is_store(input logic [LSU_OPT_WIDTH-1:0] opt);
      return (opt >= LSU_SB) && (opt <= LSU_SD);
   endfunction

   function automatic logic opt_signed(input logic [LSU_OPT_WIDTH-1:0] opt);
      return (opt == LSU_LB) || (opt == LSU_LH) || (opt == LSU_LW);
   endfunction

   function automatic lsu_size_e opt_size(input logic [LSU_OPT_WIDTH-1:0] opt);
      case (opt)
         LSU_LB, LSU_LBU, LSU_SB: return SzB;
         LSU_LH, LSU_LHU, LSU_SH: return SzH;
         LSU_LW, LSU_LWU, LSU_SW: return SzW;
         default:                 return SzD;
      endcase
   endfunction

endpackage

// File: rtl/lsu_if.sv
// LSU request/result and data-memory bus signals; slave is the LSU side, master the environment.
interface lsu_if #(
   parameter int unsigned XLEN = 64
);
   logic            i_valid;
   logic            o_ready;
   logic [3:0]      i_lsu_opt;
   logic [XLEN-1:0] i_addr;
   logic [XLEN-1:0] i_wdata;
   logic            o_valid;
   logic            i_ready;
   logic [XLEN-1:0] o_rdata;
   logic            o_misalign;
   logic            o_mem_valid;
   logic            i_mem_ready;
   logic            o_mem_wen;
   logic [XLEN-1:0] o_mem_addr;
   logic [63:0]     o_mem_wdata;
   logic [7:0]      o_mem_wmask;
   logic            i_mem_rvalid;
   logic [63:0]     i_mem_rdata;

   modport slave (
      input  i_valid, i_lsu_opt, i_addr, i_wdata, i_ready, i_mem_ready, i_mem_rvalid, i_mem_rdata,
      output o_ready, o_valid, o_rdata, o_misalign, o_mem_valid, o_mem_wen, o_mem_addr,
             o_mem_wdata, o_mem_wmask
   );

   modport master (
      output i_valid, i_lsu_opt, i_addr, i_wdata, i_ready, i_mem_ready, i_mem_rvalid, i_mem_rdata,
      input  o_ready, o_valid, o_rdata, o_misalign, o_mem_valid, o_mem_wen, o_mem_addr,
             o_mem_wdata, o_mem_wmask
   );
endinterface

// File: rtl/lsu_align.sv
// Combinational lane alignment: store lane data/strobes, load extract/extend, misalign detect.
module lsu_align
   import lsu_pkg::*;
#(
   parameter int unsigned XLEN = CPU_WIDTH
) (
   input  logic [LSU_OPT_WIDTH-1:0] opt_i,
   input  logic [2:0]               off_i,
   input  logic [XLEN-1:0]          wdata_i,
   input  logic [63:0]              rdata_i,
   output logic [63:0]              lane_wdata_o,
   output logic [7:0]               wmask_o,
   output logic [XLEN-1:0]          ext_o,
   output logic                     misalign_o
);

   lsu_size_e   size;
   logic        sext;
   logic [63:0] shifted;
   logic [63:0] ext64;
   logic [7:0]  base_mask;

   always_comb begin
      size = opt_size(opt_i);
      sext = opt_signed(opt_i);

      // Shifts drop anything pushed past lane 7 and zero-fill from above.
      lane_wdata_o = 64'(wdata_i) << {off_i, 3'b000};
      shifted      = rdata_i >> {off_i, 3'b000};

      base_mask  = 8'h00;
      ext64      = shifted;
      misalign_o = 1'b0;
      unique case (size)
         SzB: begin
            base_mask = 8'h01;
            ext64     = {{56{sext & shifted[7]}}, shifted[7:0]};
         end
         SzH: begin
            base_mask  = 8'h03;
            ext64      = {{48{sext & shifted[15]}}, shifted[15:0]};
            misalign_o = off_i[0];
         end
         SzW: begin
            base_mask  = 8'h0F;
            ext64      = {{32{sext & shifted[31]}}, shifted[31:0]};
            misalign_o = |off_i[1:0];
         end
         SzD: begin
            base_mask  = 8'hFF;
            misalign_o = |off_i;
         end
         default: ;
      endcase
      wmask_o    = base_mask << off_i;
      misalign_o = misalign_o & (opt_is_load(opt_i) | opt_is_store(opt_i));
      ext_o      = XLEN'(ext64);
   end

endmodule

// File: rtl/lsu.sv
// Load/store unit: one memory access per EXU request, one result to WBU.
// Define LSU_MISALIGN_CHECK_EN to trap misaligned accesses instead of issuing them.
module lsu
   import lsu_pkg::*;
#(
   parameter int unsigned XLEN = CPU_WIDTH
) (
   input logic  i_clk,
   input logic  i_rst,
   lsu_if.slave bus
);

`ifdef LSU_MISALIGN_CHECK_EN
   localparam bit CheckEn = 1'b1;
`else
   localparam bit CheckEn = 1'b0;
`endif

   lsu_state_e               state_q, state_d;
   logic [LSU_OPT_WIDTH-1:0] opt_q;
   logic [XLEN-1:0]          addr_q, wdata_q, rdata_q;
   logic                     misalign_q;

   logic                     in_idle, accept, is_none;
   logic [LSU_OPT_WIDTH-1:0] sel_opt;
   logic [2:0]               sel_off;
   logic [63:0]              lane_wdata;
   logic [7:0]               lane_wmask;
   logic [XLEN-1:0]          ld_ext;
   logic                     misalign;

   assign in_idle = (state_q == StIdle);
   assign accept  = in_idle & bus.i_valid;
   assign is_none = ~opt_is_load(bus.i_lsu_opt) & ~opt_is_store(bus.i_lsu_opt);

   // In IDLE the aligner looks at the incoming request so misalign is known at accept.
   assign sel_opt = in_idle ? bus.i_lsu_opt : opt_q;
   assign sel_off = in_idle ? bus.i_addr[2:0] : addr_q[2:0];

   lsu_align #(
      .XLEN(XLEN)
   ) u_align (
      .opt_i       (sel_opt),
      .off_i       (sel_off),
      .wdata_i     (wdata_q),
      .rdata_i     (bus.i_mem_rdata),
      .lane_wdata_o(lane_wdata),
      .wmask_o     (lane_wmask),
      .ext_o       (ld_ext),
      .misalign_o  (misalign)
   );

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) state_q <= StIdle;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (bus.i_valid) state_d = (is_none || (CheckEn && misalign)) ? StDone : StReq;
         StReq:   if (bus.i_mem_ready) state_d = opt_is_store(opt_q) ? StDone : StWaitR;
         StWaitR: if (bus.i_mem_rvalid) state_d = StDone;
         StDone:  if (bus.i_ready) state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      bus.o_ready     = in_idle;
      bus.o_valid     = (state_q == StDone);
      bus.o_mem_valid = (state_q == StReq);
      bus.o_mem_wen   = 1'b0;
      bus.o_mem_addr  = '0;
      bus.o_mem_wdata = '0;
      bus.o_mem_wmask = '0;
      if (state_q == StReq) begin
         bus.o_mem_addr = {addr_q[XLEN-1:3], 3'b000};
         if (opt_is_store(opt_q)) begin
            bus.o_mem_wen   = 1'b1;
            bus.o_mem_wdata = lane_wdata;
            bus.o_mem_wmask = lane_wmask;
         end
      end
      bus.o_rdata    = rdata_q;
      bus.o_misalign = misalign_q;
   end

   // Result is preloaded at accept (pass-through / zero) and overwritten by load data.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         opt_q      <= LSU_NONE;
         addr_q     <= '0;
         wdata_q    <= '0;
         rdata_q    <= '0;
         misalign_q <= 1'b0;
      end else if (accept) begin
         opt_q      <= bus.i_lsu_opt;
         addr_q     <= bus.i_addr;
         wdata_q    <= bus.i_wdata;
         misalign_q <= CheckEn & misalign;
         rdata_q    <= is_none ? bus.i_addr : '0;
      end else if ((state_q == StWaitR) && bus.i_mem_rvalid) begin
         rdata_q <= ld_ext;
      end
   end

endmodule

// File: tb/tb_lsu.sv
// Directed plus randomized bench for lsu against a byte-level reference model.
module tb_lsu;
   import lsu_pkg::*;

`ifdef LSU_MISALIGN_CHECK_EN
   localparam bit ChkEn = 1'b1;
`else
   localparam bit ChkEn = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;

   logic [63:0] cap_maddr, cap_mwdata, got;
   logic [7:0]  cap_mask;
   logic        cap_req, cap_mis;

   always #5 clk = ~clk;

   lsu_if #(.XLEN(64)) bus ();

   lsu #(.XLEN(64)) dut (
      .i_clk(clk),
      .i_rst(rst),
      .bus  (bus)
   );

   typedef struct {
      logic [63:0] maddr;
      logic [7:0]  mask;
      logic [63:0] mwdata;
      logic [63:0] res;
      logic        mis;
      bit          is_ld;
      bit          is_st;
      bit          skip;
   } exp_t;

   function automatic exp_t model(input logic [3:0] opt, input logic [63:0] addr,
                                  input logic [63:0] wdata, input logic [63:0] rdata);
      exp_t e;
      int   n, off, lane;
      bit   sgn;
      e = '{maddr: '0, mask: '0, mwdata: '0, res: '0, mis: 1'b0, is_ld: 0, is_st: 0, skip: 0};
      off = int'(addr % 8);
      sgn = 0;
      case (opt)
         4'd1: begin n = 1; sgn = 1; end
         4'd2: begin n = 2; sgn = 1; end
         4'd3: begin n = 4; sgn = 1; end
         4'd4: n = 8;
         4'd5: n = 1;
         4'd6: n = 2;
         4'd7: n = 4;
         4'd8: n = 1;
         4'd9: n = 2;
         4'd10: n = 4;
         4'd11: n = 8;
         default: n = 0;
      endcase
      e.is_ld = (opt >= 1) && (opt <= 7);
      e.is_st = (opt >= 8) && (opt <= 11);
      if (!e.is_ld && !e.is_st) begin
         e.res  = addr;
         e.skip = 1;
         return e;
      end
      e.mis = ChkEn && ((off % n) != 0);
      if (e.mis) begin
         e.skip = 1;
         return e;
      end
      e.maddr = addr & ~64'h7;
      for (int i = 0; i < 8; i++) begin
         lane = off + i;
         if (lane < 8) begin
            e.mwdata[lane*8 +: 8] = wdata[i*8 +: 8];
            if (i < n) begin
               e.mask[lane] = 1'b1;
               e.res[i*8 +: 8] = rdata[lane*8 +: 8];
            end
         end
      end
      if (e.is_st) e.res = '0;
      else if (sgn && e.res[n*8-1])
         for (int j = n * 8; j < 64; j++) e.res[j] = 1'b1;
      return e;
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic noise();
      bus.i_mem_rvalid = 1'($urandom);
      bus.i_mem_rdata  = {$urandom, $urandom};
   endtask

   // Runs one instruction from accept to the IDLE return, checking each cycle.
   task automatic run_op(input logic [3:0] opt, input logic [63:0] addr, input logic [63:0] wdata,
                         input logic [63:0] rdata, input int rdy_dly, input int rv_dly,
                         input int acc_dly);
      exp_t e;
      e = model(opt, addr, wdata, rdata);
      cap_req = 1'b0;
      @(negedge clk);
      check("idle_ready", 64'(bus.o_ready), 64'd1);
      bus.i_valid = 1'b1; bus.i_lsu_opt = opt; bus.i_addr = addr; bus.i_wdata = wdata;
      bus.i_ready = 1'b0; bus.i_mem_ready = 1'b0; bus.i_mem_rvalid = 1'b0;
      @(negedge clk);
      // Garbage on the request side must be ignored while busy.
      bus.i_valid = 1'($urandom); bus.i_lsu_opt = 4'($urandom_range(0, 11));
      bus.i_addr = {$urandom, $urandom}; bus.i_wdata = {$urandom, $urandom};
      if (!e.skip) begin
         for (int k = 0; k <= rdy_dly; k++) begin
            check("req_valid", 64'(bus.o_mem_valid), 64'd1);
            check("req_addr", bus.o_mem_addr, e.maddr);
            check("req_wen", 64'(bus.o_mem_wen), 64'(e.is_st));
            check("req_busy", 64'({bus.o_ready, bus.o_valid}), 64'd0);
            if (e.is_st) begin
               check("req_wmask", 64'(bus.o_mem_wmask), 64'(e.mask));
               check("req_wdata", bus.o_mem_wdata, e.mwdata);
            end
            if (k == 0) begin
               cap_req = 1'b1; cap_maddr = bus.o_mem_addr;
               cap_mask = bus.o_mem_wmask; cap_mwdata = bus.o_mem_wdata;
            end
            bus.i_mem_ready = (k == rdy_dly);
            noise();
            @(negedge clk);
         end
         bus.i_mem_ready = 1'b0;
         bus.i_mem_rvalid = 1'b0;
         if (e.is_ld) begin
            for (int k = 0; k <= rv_dly; k++) begin
               check("wait_quiet", 64'({bus.o_mem_valid, bus.o_valid}), 64'd0);
               bus.i_mem_rvalid = (k == rv_dly);
               bus.i_mem_rdata  = (k == rv_dly) ? rdata : {$urandom, $urandom};
               @(negedge clk);
            end
            bus.i_mem_rvalid = 1'b0;
         end
      end
      got = bus.o_rdata;
      cap_mis = bus.o_misalign;
      for (int k = 0; k <= acc_dly; k++) begin
         check("done_valid", 64'(bus.o_valid), 64'd1);
         check("done_rdata", bus.o_rdata, e.res);
         check("done_misalign", 64'(bus.o_misalign), 64'(e.mis));
         check("done_busy", 64'({bus.o_ready, bus.o_mem_valid}), 64'd0);
         bus.i_ready = (k == acc_dly);
         noise();
         @(negedge clk);
      end
      bus.i_ready = 1'b0; bus.i_valid = 1'b0; bus.i_mem_rvalid = 1'b0;
      check("back_idle", 64'({bus.o_ready, bus.o_valid}), 64'b10);
   endtask

   initial begin
      bus.i_valid = 1'b0; bus.i_lsu_opt = '0; bus.i_addr = '0; bus.i_wdata = '0;
      bus.i_ready = 1'b0; bus.i_mem_ready = 1'b0; bus.i_mem_rvalid = 1'b0; bus.i_mem_rdata = '0;
      @(negedge clk);
      check("rst_ready", 64'(bus.o_ready), 64'd1);
      check("rst_valid", 64'({bus.o_valid, bus.o_mem_valid, bus.o_mem_wen, bus.o_misalign}), 64'd0);
      check("rst_addr", bus.o_mem_addr, 64'd0);
      check("rst_wdata", bus.o_mem_wdata, 64'd0);
      check("rst_wmask", 64'(bus.o_mem_wmask), 64'd0);
      check("rst_rdata", bus.o_rdata, 64'd0);
      @(negedge clk);
      rst = 1'b0;

      run_op(LSU_SB, 64'h8000_0005, 64'hAB, 64'h0, 0, 0, 0);
      check("sb_req", 64'(cap_req), 64'd1);
      check("sb_addr", cap_maddr, 64'h8000_0000);
      check("sb_mask", 64'(cap_mask), 64'h20);
      check("sb_wdata", cap_mwdata, 64'h0000_AB00_0000_0000);

      run_op(LSU_LB, 64'h1003, 64'h0, 64'h0000_0000_8000_0000, 0, 0, 0);
      check("lb_sext", got, 64'hFFFF_FFFF_FFFF_FF80);
      run_op(LSU_LBU, 64'h1003, 64'h0, 64'h0000_0000_8000_0000, 1, 1, 0);
      check("lbu_zext", got, 64'h80);
      run_op(LSU_LW, 64'h2004, 64'h0, 64'h1234_5678_0000_0000, 0, 0, 1);
      check("lw_val", got, 64'h0000_0000_1234_5678);
      run_op(LSU_LD, 64'h2008, 64'h0, 64'hCAFE_F00D_1357_9BDF, 3, 2, 0);
      check("ld_val", got, 64'hCAFE_F00D_1357_9BDF);
      run_op(LSU_NONE, 64'hDEAD, 64'h5555, 64'h0, 0, 0, 4);
      check("none_pass", got, 64'hDEAD);

      run_op(LSU_LH, 64'h3001, 64'h0, 64'h0123_4567_89AB_CDEF, 0, 1, 0);
      if (ChkEn) begin
         check("lh_mis_noreq", 64'(cap_req), 64'd0);
         check("lh_mis_flag", 64'(cap_mis), 64'd1);
      end else begin
         check("lh_req_addr", cap_maddr, 64'h3000);
         check("lh_mis_flag", 64'(cap_mis), 64'd0);
      end

      // Reset while the bus request is outstanding.
      @(negedge clk);
      bus.i_valid = 1'b1; bus.i_lsu_opt = LSU_LD; bus.i_addr = 64'h4000;
      @(negedge clk);
      bus.i_valid = 1'b0;
      check("rst_mid_req", 64'(bus.o_mem_valid), 64'd1);
      #2 rst = 1'b1;
      #1;
      check("rst_mid_drop", 64'(bus.o_mem_valid), 64'd0);
      check("rst_mid_ready", 64'(bus.o_ready), 64'd1);
      @(negedge clk);
      rst = 1'b0;
      bus.i_mem_rvalid = 1'b1; bus.i_mem_rdata = {$urandom, $urandom};
      @(negedge clk);
      bus.i_mem_rvalid = 1'b0;
      for (int k = 0; k < 3; k++) begin
         check("rst_no_result", 64'({bus.o_valid, bus.o_mem_valid}), 64'd0);
         @(negedge clk);
      end

      for (int t = 0; t < 200; t++) begin
         run_op(4'($urandom_range(0, 11)), {$urandom, $urandom}, {$urandom, $urandom},
                {$urandom, $urandom}, $urandom_range(0, 3), $urandom_range(0, 3),
                $urandom_range(0, 2));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
